wf_scan_ctrl: RTL and testbench

Autonomous scan controller for the SSD1306 waveform peripheral. It samples the 8 `ui_in` channels at a programmable rate and packs 8 consecutive samples per channel into a byte. It then drives the peripheral's register port (track select, then pixel write), polling its idle status between commands, so the CPU does not have to poke every pixel byte. It sits between the CPU-visible configuration registers and the waveform peripheral's `address`/`data_write`/`data_in`/`data_out` port.

---
 rtl/wf_pkg.sv | 23 ++
 rtl/wf_sample_capture.sv | 54 +++++
 rtl/wf_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_wf_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wf_pkg.sv
// Shared constants and flush-state encoding for the waveform scan controller.
package wf_pkg;

  localparam logic [3:0] WF_ADDR_PIXEL   = 4'h0;
  localparam logic [3:0] WF_ADDR_SPI     = 4'h1;
  localparam logic [3:0] WF_ADDR_DCPRESC = 4'h2;
  localparam logic [3:0] WF_ADDR_SEL     = 4'h8;

  localparam int WF_IDLE_BIT = 0;

  // Two cycles of blind wait cover the peripheral's delay before status drops.
  localparam logic [1:0] WF_GUARD_INIT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL_ISSUE,
    ST_SEL_WAIT,
    ST_PIX_ISSUE,
    ST_PIX_WAIT,
    ST_NEXT
  } wf_flush_state_t;

endpackage

// File: rtl/wf_sample_capture.sv
// Sample-rate divider plus per-channel 8-bit shift registers; flags each completed byte.
module wf_sample_capture
  import wf_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_in,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             byte_done,
  output logic [7:0]       bytes [NCH]
);

  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_smp_cnt;
  logic             w_tick;

  assign w_tick    = cfg_en && (r_div_cnt == '0);
  assign byte_done = w_tick && (r_smp_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_smp_cnt <= '0;
    end else if (!cfg_en) begin
      r_div_cnt <= cfg_div;
      r_smp_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= cfg_div;
      r_smp_cnt <= r_smp_cnt + 3'd1;
    end else begin
      r_div_cnt <= r_div_cnt - DIV_W'(1);
    end
  end

  // bytes[] shows the post-shift value so the hold buffer can take it on the completing tick.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [7:0] r_sreg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sreg <= '0;
      end else if (w_tick) begin
        r_sreg <= {r_sreg[6:0], ch_in[gi]};
      end
    end

    assign bytes[gi] = {r_sreg[6:0], ch_in[gi]};
  end

endmodule

// File: rtl/wf_scan_ctrl.sv
// Scan controller: captures channel bytes, buffers one set, and flushes it to the
// waveform peripheral as track-select / pixel-write command pairs.
module wf_scan_ctrl
  import wf_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_in,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [NCH-1:0]   cfg_mask,
  output logic [3:0]       wf_address,
  output logic             wf_write,
  output logic [7:0]       wf_data,
  input  logic [7:0]       wf_status,
  output logic             busy,
  output logic             overrun
);

  localparam int TW = (NCH > 1) ? $clog2(NCH) : 1;

  // Returns {found, index} of the lowest set mask bit at or above lo.
  function automatic logic [TW:0] first_set(input logic [NCH-1:0] mask, input int lo);
    logic [TW:0] res;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= lo)) begin
        res = {1'b1, TW'(i)};
      end
    end
    return res;
  endfunction

  wf_flush_state_t r_state, w_state_next;
  logic [TW-1:0]   r_trk, w_trk_next;
  logic [NCH-1:0]  r_mask, w_mask_next;
  logic [1:0]      r_guard, w_guard_next;
  logic            r_wf_write, w_wr_next;
  logic [3:0]      r_wf_address, w_addr_next;
  logic [7:0]      r_wf_data, w_data_next;
  logic            r_hold_valid;
  logic            r_overrun;
  logic            r_en_d;
  logic [7:0]      r_hold [NCH];

  logic            w_flush_done;
  logic [TW:0]     w_find;
  logic            w_byte_done;
  logic [7:0]      w_bytes [NCH];
  logic            w_accept;
  logic            w_periph_idle;
  logic            w_unused_status;

  assign w_periph_idle   = wf_status[WF_IDLE_BIT];
  assign w_unused_status = ^wf_status[7:1];

  wf_sample_capture #(
    .NCH   (NCH),
    .DIV_W (DIV_W)
  ) u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_in     (ch_in),
    .cfg_en    (cfg_en),
    .cfg_div   (cfg_div),
    .byte_done (w_byte_done),
    .bytes     (w_bytes)
  );

  // Write strobe and its address/data are computed one state ahead so wf_write is a flop.
  always_comb begin
    w_state_next = r_state;
    w_trk_next   = r_trk;
    w_mask_next  = r_mask;
    w_guard_next = r_guard;
    w_wr_next    = 1'b0;
    w_addr_next  = r_wf_address;
    w_data_next  = r_wf_data;
    w_flush_done = 1'b0;
    w_find       = '0;

    case (r_state)
      ST_IDLE: begin
        if (r_hold_valid) begin
          w_find      = first_set(cfg_mask, 0);
          w_mask_next = cfg_mask;
          if (w_find[TW]) begin
            w_trk_next   = w_find[TW-1:0];
            w_state_next = ST_SEL_ISSUE;
            w_wr_next    = 1'b1;
            w_addr_next  = WF_ADDR_SEL;
            w_data_next  = 8'(w_find[TW-1:0]);
          end else begin
            w_flush_done = 1'b1;
          end
        end
      end
      ST_SEL_ISSUE: begin
        w_guard_next = WF_GUARD_INIT;
        w_state_next = ST_SEL_WAIT;
      end
      ST_SEL_WAIT: begin
        if (r_guard != 2'd0) begin
          w_guard_next = r_guard - 2'd1;
        end else if (w_periph_idle) begin
          w_state_next = ST_PIX_ISSUE;
          w_wr_next    = 1'b1;
          w_addr_next  = WF_ADDR_PIXEL;
          w_data_next  = r_hold[r_trk];
        end
      end
      ST_PIX_ISSUE: begin
        w_guard_next = WF_GUARD_INIT;
        w_state_next = ST_PIX_WAIT;
      end
      ST_PIX_WAIT: begin
        if (r_guard != 2'd0) begin
          w_guard_next = r_guard - 2'd1;
        end else if (w_periph_idle) begin
          w_state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        w_find = first_set(r_mask, int'(r_trk) + 1);
        if (w_find[TW]) begin
          w_trk_next   = w_find[TW-1:0];
          w_state_next = ST_SEL_ISSUE;
          w_wr_next    = 1'b1;
          w_addr_next  = WF_ADDR_SEL;
          w_data_next  = 8'(w_find[TW-1:0]);
        end else begin
          w_state_next = ST_IDLE;
          w_flush_done = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A finishing flush frees the hold buffer in the same cycle a new set may arrive.
  assign w_accept = w_byte_done && (!r_hold_valid || w_flush_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_trk        <= '0;
      r_mask       <= '0;
      r_guard      <= '0;
      r_wf_write   <= 1'b0;
      r_wf_address <= '0;
      r_wf_data    <= '0;
      r_hold_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_en_d       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_trk        <= w_trk_next;
      r_mask       <= w_mask_next;
      r_guard      <= w_guard_next;
      r_wf_write   <= w_wr_next;
      r_wf_address <= w_addr_next;
      r_wf_data    <= w_data_next;
      r_en_d       <= cfg_en;

      if (w_accept) begin
        r_hold_valid <= 1'b1;
      end else if (w_flush_done) begin
        r_hold_valid <= 1'b0;
      end

      if (cfg_en && !r_en_d) begin
        r_overrun <= 1'b0;
      end else if (w_byte_done && !w_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NCH; i++) begin
        r_hold[i] <= w_bytes[i];
      end
    end
  end

  assign wf_address = r_wf_address;
  assign wf_write   = r_wf_write;
  assign wf_data    = r_wf_data;
  assign busy       = (r_state != ST_IDLE) || r_hold_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_wf_scan_ctrl.sv
// Directed bench for wf_scan_ctrl: expected peripheral writes are queued by the
// stimulus and consumed by a monitor that also models the peripheral's idle status.
module tb_wf_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ch_in;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_mask;
  logic [3:0]  wf_address;
  logic        wf_write;
  logic [7:0]  wf_data;
  logic [7:0]  wf_status;
  logic        busy;
  logic        overrun;

  wf_scan_ctrl #(
    .NCH   (8),
    .DIV_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_in      (ch_in),
    .cfg_en     (cfg_en),
    .cfg_div    (cfg_div),
    .cfg_mask   (cfg_mask),
    .wf_address (wf_address),
    .wf_write   (wf_write),
    .wf_data    (wf_data),
    .wf_status  (wf_status),
    .busy       (busy),
    .overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_writes = 0;
  int last_wr_cyc = 0;
  int last_sel_cyc = 0;
  bit have_last = 1'b0;
  int busy_len = 0;
  int p_busy = 0;
  bit p_start = 1'b0;
  logic [11:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard plus peripheral status model (status drops one cycle after a write).
  always @(negedge clk) begin
    logic [11:0] e;
    if (wf_write) begin
      n_writes++;
      $display("wr cyc=%0d addr=%0h data=%02h", cyc, wf_address, wf_data);
      checks++;
      if (wf_status[0] !== 1'b1) begin
        errors++;
        $display("FAIL wr_while_busy: status bit0=%0b, required 1", wf_status[0]);
      end
      if (have_last) begin
        checks++;
        if (cyc - last_wr_cyc < 3) begin
          errors++;
          $display("FAIL wr_spacing: gap=%0d cycles, required >=3", cyc - last_wr_cyc);
        end
      end
      have_last   = 1'b1;
      last_wr_cyc = cyc;
      if (wf_address == 4'h8) last_sel_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr: got addr=%0h data=%02h, required no write", wf_address, wf_data);
      end else begin
        e = exp_q.pop_front();
        if ({wf_address, wf_data} !== e) begin
          errors++;
          $display("FAIL wr_value: got addr=%0h data=%02h, required addr=%0h data=%02h",
                   wf_address, wf_data, e[11:8], e[7:0]);
        end
      end
    end
    if (p_busy > 0) p_busy--;
    if (p_start) begin
      p_busy  = busy_len;
      p_start = 1'b0;
    end
    if (wf_write && busy_len > 0) p_start = 1'b1;
    wf_status = {7'b0, (p_busy == 0)};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Sample k of the set is smp[63-8k -: 8]; returns the cycle whose tick completes the byte.
  task automatic send_set(input logic [63:0] smp, input bit keep, output int done_cyc);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cfg_en = 1'b1;
      ch_in  = smp[63-8*k -: 8];
    end
    done_cyc = cyc;
    if (!keep) begin
      @(negedge clk);
      cfg_en = 1'b0;
      ch_in  = '0;
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int i;
    i = 0;
    while ((busy || exp_q.size() != 0) && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: busy=%0b pending_writes=%0d after %0d cycles, required 0 and 0",
               name, busy, exp_q.size(), max_cyc);
    end
  endtask

  initial begin
    int dc;
    int base;
    int i;

    rst_n     = 1'b0;
    ch_in     = '0;
    cfg_en    = 1'b0;
    cfg_div   = '0;
    cfg_mask  = 8'h01;
    wf_status = 8'h01;
    #1;
    check("rst_address", 32'(wf_address), 32'h0);
    check("rst_write",   32'(wf_write),   32'h0);
    check("rst_data",    32'(wf_data),    32'h0);
    check("rst_busy",    32'(busy),       32'h0);
    check("rst_overrun", 32'(overrun),    32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single track, always-idle peripheral.
    busy_len = 0;
    cfg_mask = 8'h01;
    base = n_writes;
    expect_wr(4'h8, 8'h00);
    expect_wr(4'h0, 8'hB1);
    send_set(64'h01_00_01_01_00_00_00_01, 1'b0, dc);
    wait_idle(100, "t1_idle");
    check("t1_nwrites", 32'(n_writes - base), 32'd2);
    check("t1_overrun", 32'(overrun), 32'h0);

    // Tracks 1 and 3 through a peripheral busy 20 cycles per command.
    busy_len = 20;
    cfg_mask = 8'h0A;
    expect_wr(4'h8, 8'h01);
    expect_wr(4'h0, 8'h5A);
    expect_wr(4'h8, 8'h03);
    expect_wr(4'h0, 8'hC3);
    send_set(64'h09_0B_01_03_03_01_0B_09, 1'b0, dc);
    wait_idle(400, "t2_idle");
    repeat (30) @(negedge clk);

    // Empty mask: two sets, no writes, hold cleared immediately.
    busy_len = 0;
    cfg_mask = 8'h00;
    base = n_writes;
    send_set(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, dc);
    send_set(64'hA5A5_A5A5_A5A5_A5A5, 1'b0, dc);
    check("t3_hold_set", 32'(busy), 32'h1);
    @(negedge clk);
    check("t3_hold_clr", 32'(busy), 32'h0);
    repeat (10) @(negedge clk);
    check("t3_nwrites", 32'(n_writes - base), 32'd0);
    check("t3_overrun", 32'(overrun), 32'h0);

    // Slow peripheral: second set dropped while the first is flushing.
    busy_len = 500;
    cfg_mask = 8'hFF;
    for (int t = 0; t < 8; t++) begin
      expect_wr(4'h8, 8'(t));
      expect_wr(4'h0, (t >= 4) ? 8'hFF : 8'h00);
    end
    send_set(64'hF0F0_F0F0_F0F0_F0F0, 1'b1, dc);
    send_set(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, dc);
    check("t4_overrun_set", 32'(overrun), 32'h1);
    cfg_div = 16'd1000;
    @(negedge clk);
    check("t4_overrun_sticky", 32'(overrun), 32'h1);
    cfg_en = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
    check("t4_overrun_clr", 32'(overrun), 32'h0);
    @(negedge clk);
    cfg_div = '0;
    wait_idle(10000, "t4_idle");
    repeat (30) @(negedge clk);

    // Asynchronous reset between SEL and PIX.
    busy_len = 20;
    cfg_mask = 8'h01;
    base = n_writes;
    expect_wr(4'h8, 8'h00);
    send_set(64'h01_00_01_01_00_00_00_01, 1'b0, dc);
    i = 0;
    while (n_writes == base && i < 30) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("t5_sel_seen", 32'(n_writes - base), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_address", 32'(wf_address), 32'h0);
    check("t5_rst_write",   32'(wf_write),   32'h0);
    check("t5_rst_busy",    32'(busy),       32'h0);
    check("t5_rst_overrun", 32'(overrun),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t5_no_pix", 32'(n_writes - base), 32'd1);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // New byte completes on the exact cycle the previous flush finishes.
    busy_len = 0;
    cfg_mask = 8'h01;
    expect_wr(4'h8, 8'h00);
    expect_wr(4'h0, 8'h3C);
    expect_wr(4'h8, 8'h00);
    expect_wr(4'h0, 8'hE7);
    send_set(64'h00_00_01_01_01_01_00_00, 1'b0, dc);
    @(negedge clk);
    send_set(64'h01_01_01_00_00_01_01_01, 1'b0, dc);
    wait_idle(100, "t6_idle");
    check("t6_overrun", 32'(overrun), 32'h0);
    check("t6_sel_latency", 32'(last_sel_cyc - dc), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
